path_tracer: RTL



---
 rtl/path_tracer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/path_tracer.sv
// path_tracer: walks per-node direction fields from a goal node back to the source,
// emitting one step per node on a valid/ready stream.
// Ports: clk/rst (async active-low); start/abort/goal_x/goal_y control;
// rd_en/rd_x/rd_y request and rd_cost/rd_dir reply (one-cycle latency);
// step_* output stream; busy/done/status report progress and outcome.
module path_tracer #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int COST_SIZE = 12,
  parameter int MAX_STEPS = GRID_W * GRID_H,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int S = COST_SIZE,
  localparam int CW = $clog2(MAX_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] goal_x,
  input  logic [YW-1:0] goal_y,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [S-1:0]  rd_cost,
  input  logic [3:0]    rd_dir,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [XW-1:0] step_x,
  output logic [YW-1:0] step_y,
  output logic [3:0]    step_dir,
  output logic          step_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;
  state_t state, state_nx;
  logic [XW-1:0] cur_x, nxt_x, px;
  logic [YW-1:0] cur_y, nxt_y, py;
  logic [CW-1:0] cnt, cnt_inc;
  logic [S-1:0] prev_cost;
  logic [2:0] d;
  logic xm, xp, ym, yp, oob, unreach, loop_c, bad, hs, go;
  logic [1:0] bad_status;
  assign d = rd_dir[2:0];
  assign xp = d inside {3'd1, 3'd2, 3'd3};
  assign xm = d inside {3'd5, 3'd6, 3'd7};
  assign ym = d inside {3'd7, 3'd0, 3'd1};
  assign yp = d inside {3'd3, 3'd4, 3'd5};
  assign px = xp ? cur_x + XW'(1) : xm ? cur_x - XW'(1) : cur_x;
  assign py = yp ? cur_y + YW'(1) : ym ? cur_y - YW'(1) : cur_y;
  // Edge checks on the current node instead of the sum, so wrap-around is caught.
  assign oob = (xm && cur_x == '0) || (xp && cur_x == XW'(GRID_W - 1)) ||
               (ym && cur_y == '0) || (yp && cur_y == YW'(GRID_H - 1));
  assign unreach = &rd_cost;
  // Cost must strictly decrease along the path; the first node has no predecessor cost.
  assign loop_c = cnt != '0 && rd_cost >= prev_cost;
  assign bad = unreach || loop_c || (!rd_dir[3] && rd_cost != '0) || (rd_dir[3] && oob);
  assign bad_status = unreach ? 2'd1 : (loop_c || !rd_dir[3]) ? 2'd3 : 2'd2;
  assign hs = step_valid && step_ready;
  assign go = !abort;
  assign cnt_inc = cnt + CW'(1);
  assign rd_en = state == READ;
  assign rd_x = cur_x;
  assign rd_y = cur_y;
  assign step_valid = state == EMIT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? READ : IDLE;
      READ: state_nx = WAIT;
      WAIT: state_nx = bad ? DONE : EMIT;
      EMIT: state_nx = !hs ? EMIT : (step_last || cnt_inc == CW'(MAX_STEPS)) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      nxt_x <= '0;
      nxt_y <= '0;
      cnt <= '0;
      prev_cost <= '0;
      step_x <= '0;
      step_y <= '0;
      step_dir <= '0;
      step_last <= 1'b0;
      status <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && go) begin
        cur_x <= goal_x;
        cur_y <= goal_y;
        cnt <= '0;
        prev_cost <= '1;
      end
      if (state == WAIT && go) begin
        if (bad) status <= bad_status;
        else begin
          step_x <= cur_x;
          step_y <= cur_y;
          step_dir <= rd_dir;
          step_last <= !rd_dir[3];
          nxt_x <= px;
          nxt_y <= py;
          prev_cost <= rd_cost;
        end
      end
      if (state == EMIT && hs && go) begin
        if (step_last) status <= 2'd0;
        else begin
          cur_x <= nxt_x;
          cur_y <= nxt_y;
          cnt <= cnt_inc;
          if (cnt_inc == CW'(MAX_STEPS)) status <= 2'd3;
        end
      end
    end
  end
endmodule
